// File: rtl/genius_pkg.sv
// Shared state codes and timer sizing for the genius control unit.
package genius_pkg;

   localparam logic [3:0] INICIAL     = 4'd0;
   localparam logic [3:0] PREPARA     = 4'd1;
   localparam logic [3:0] ESPERA      = 4'd2;
   localparam logic [3:0] REGISTRA    = 4'd3;
   localparam logic [3:0] COMPARA     = 4'd4;
   localparam logic [3:0] PROXIMO     = 4'd5;
   localparam logic [3:0] FIM_ACERTO  = 4'd6;
   localparam logic [3:0] FIM_ERRO    = 4'd7;
   localparam logic [3:0] PROX_RODADA = 4'd8;
   localparam logic [3:0] MOSTRA      = 4'd9;
   localparam logic [3:0] INTERVALO   = 4'd10;
   localparam logic [3:0] INICIO_RESP = 4'd11;
   localparam logic [3:0] FIM_TIMEOUT = 4'd15;

   // Width able to hold (largest cycle limit - 1), never less than one bit.
   function automatic int unsigned timer_w(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/genius_ctrl_param_if.sv
// Control <-> datapath/panel bundle; master is the control unit, slave is the other side.
interface genius_ctrl_param_if #(
   parameter int unsigned ADDR_W = 4
);
   logic              iniciar;
   logic              modo;
   logic              jogada;
   logic              igual;
   logic [ADDR_W-1:0] endereco;
   logic [ADDR_W-1:0] limite;
   logic              zeraR;
   logic              registraR;
   logic              mostra;
   logic              acertou;
   logic              errou;
   logic              timeout;
   logic              pronto;
   logic [3:0]        db_estado;

   modport master (
      input  iniciar, modo, jogada, igual,
      output endereco, limite, zeraR, registraR, mostra,
      output acertou, errou, timeout, pronto, db_estado
   );

   modport slave (
      output iniciar, modo, jogada, igual,
      input  endereco, limite, zeraR, registraR, mostra,
      input  acertou, errou, timeout, pronto, db_estado
   );
endinterface

// File: rtl/genius_timer.sv
// Shared cycle counter: clear has priority over enable; done compares against a terminal value.
module genius_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] term_i,
   output logic         done_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == term_i);
endmodule

// File: rtl/genius_ctrl_param.sv
// Genius game control unit with internal address/round/timer counters.
// Optional sequence replay before each response phase: define GENIUS_SHOW_SEQ_EN.
module genius_ctrl_param
   import genius_pkg::*;
#(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned ROUNDS_EASY = 4,
   parameter int unsigned TIMEOUT_CYC = 5000,
   parameter int unsigned SHOW_CYC    = 1000,
   parameter int unsigned GAP_CYC     = 250
) (
   input logic                 clock,
   input logic                 reset,
   genius_ctrl_param_if.master bus
);
   localparam int unsigned TW = timer_w(TIMEOUT_CYC, SHOW_CYC, GAP_CYC);
   localparam logic [TW-1:0] TermTimeout = TW'(TIMEOUT_CYC - 1);
`ifdef GENIUS_SHOW_SEQ_EN
   localparam logic [TW-1:0] TermShow = TW'(SHOW_CYC - 1);
   localparam logic [TW-1:0] TermGap  = TW'(GAP_CYC - 1);
   localparam logic [3:0]    AfterSetup = MOSTRA;
`else
   localparam logic [3:0]    AfterSetup = ESPERA;
`endif

   logic [3:0]        state_q, state_d;
   logic [ADDR_W-1:0] endereco_q, endereco_d;
   logic [ADDR_W-1:0] limite_q, limite_d;
   logic              modo_q, modo_d;
   logic [ADDR_W-1:0] last;
   logic [TW-1:0]     tmr_term;
   logic              tmr_en;
   logic              tmr_done;

   assign last = modo_q ? '1 : ADDR_W'(ROUNDS_EASY - 1);

   genius_timer #(.W(TW)) u_timer (
      .clock  (clock),
      .reset  (reset),
      .clr_i  (state_d != state_q),
      .en_i   (tmr_en),
      .term_i (tmr_term),
      .done_o (tmr_done)
   );

   // Counter updates are entry actions, so the new values are visible in the state they belong to.
   always_comb begin
      state_d    = state_q;
      endereco_d = endereco_q;
      limite_d   = limite_q;
      modo_d     = modo_q;
      tmr_term   = TermTimeout;
      tmr_en     = 1'b0;
      case (state_q)
         INICIAL: begin
            if (bus.iniciar) state_d = PREPARA;
         end
         PREPARA: begin
            modo_d  = bus.modo;
            state_d = AfterSetup;
         end
`ifdef GENIUS_SHOW_SEQ_EN
         MOSTRA: begin
            tmr_term = TermShow;
            tmr_en   = 1'b1;
            if (tmr_done) state_d = INTERVALO;
         end
         INTERVALO: begin
            tmr_term = TermGap;
            tmr_en   = 1'b1;
            if (tmr_done) begin
               if (endereco_q == limite_q) begin
                  state_d    = INICIO_RESP;
                  endereco_d = '0;
               end else begin
                  state_d    = MOSTRA;
                  endereco_d = endereco_q + ADDR_W'(1);
               end
            end
         end
         INICIO_RESP: begin
            state_d = ESPERA;
         end
`endif
         ESPERA: begin
            tmr_en = 1'b1;
            if (bus.jogada) begin
               state_d = REGISTRA;
            end else if (tmr_done) begin
               state_d = FIM_TIMEOUT;
            end
         end
         REGISTRA: begin
            state_d = COMPARA;
         end
         COMPARA: begin
            if (!bus.igual) begin
               state_d = FIM_ERRO;
            end else if (endereco_q != limite_q) begin
               state_d    = PROXIMO;
               endereco_d = endereco_q + ADDR_W'(1);
            end else if (limite_q == last) begin
               state_d = FIM_ACERTO;
            end else begin
               state_d    = PROX_RODADA;
               limite_d   = limite_q + ADDR_W'(1);
               endereco_d = '0;
            end
         end
         PROXIMO: begin
            state_d = ESPERA;
         end
         PROX_RODADA: begin
            state_d = AfterSetup;
         end
         FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
            if (bus.iniciar) state_d = PREPARA;
         end
         default: begin
            state_d = INICIAL;
         end
      endcase
      if (state_d == PREPARA) begin
         endereco_d = '0;
         limite_d   = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= INICIAL;
         endereco_q <= '0;
         limite_q   <= '0;
         modo_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         endereco_q <= endereco_d;
         limite_q   <= limite_d;
         modo_q     <= modo_d;
      end
   end

   always_comb begin
      bus.endereco  = endereco_q;
      bus.limite    = limite_q;
      bus.db_estado = state_q;
      bus.zeraR     = (state_q == INICIAL) || (state_q == PREPARA) || (state_q == PROXIMO) ||
                      (state_q == PROX_RODADA) || (state_q == INICIO_RESP);
      bus.registraR = (state_q == REGISTRA);
`ifdef GENIUS_SHOW_SEQ_EN
      bus.mostra    = (state_q == MOSTRA);
`else
      bus.mostra    = 1'b0;
`endif
      bus.acertou   = (state_q == FIM_ACERTO);
      bus.errou     = (state_q == FIM_ERRO);
      bus.timeout   = (state_q == FIM_TIMEOUT);
      bus.pronto    = (state_q == FIM_ACERTO) || (state_q == FIM_ERRO) ||
                      (state_q == FIM_TIMEOUT);
   end
endmodule

// File: tb/tb_genius_ctrl_param.sv
// Scoreboard bench: expected state trace is queued ahead of stimulus; a monitor checks each
// state change (code, counters, decoded outputs) and the dwell time of the state just left.
module tb_genius_ctrl_param;
   import genius_pkg::*;

   localparam int unsigned AW = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   genius_ctrl_param_if #(.ADDR_W(AW)) bus ();

   genius_ctrl_param #(
      .ADDR_W      (AW),
      .ROUNDS_EASY (2),
      .TIMEOUT_CYC (10),
      .SHOW_CYC    (3),
      .GAP_CYC     (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0]    st;
      logic [AW-1:0] en;
      logic [AW-1:0] li;
      logic [7:0]    dur;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   logic [3:0]  cur_st = INICIAL;
   int unsigned dwell = 0;
   int unsigned cur_dur = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] outs_of(input logic [3:0] s);
      logic z, fin;
      z   = (s == INICIAL) || (s == PREPARA) || (s == INICIO_RESP) || (s == PROXIMO) ||
            (s == PROX_RODADA);
      fin = (s == FIM_ACERTO) || (s == FIM_ERRO) || (s == FIM_TIMEOUT);
      return {z, s == REGISTRA, s == MOSTRA, s == FIM_ACERTO, s == FIM_ERRO, s == FIM_TIMEOUT,
              fin};
   endfunction

   function automatic logic [6:0] outs_dut();
      return {bus.zeraR, bus.registraR, bus.mostra, bus.acertou, bus.errou, bus.timeout,
              bus.pronto};
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (mon_en) begin
         if (bus.db_estado !== cur_st) begin
            if (cur_dur != 0) chk($sformatf("dwell_st%0d", cur_st), dwell, cur_dur);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_state: got %0d, expected no further change",
                        bus.db_estado);
               cur_dur = 0;
            end else begin
               e = q.pop_front();
               chk("db_estado", bus.db_estado, e.st);
               chk($sformatf("endereco_st%0d", e.st), bus.endereco, e.en);
               chk($sformatf("limite_st%0d", e.st), bus.limite, e.li);
               chk($sformatf("outputs_st%0d", e.st), outs_dut(), outs_of(e.st));
               cur_dur = e.dur;
            end
            cur_st = bus.db_estado;
            dwell  = 1;
         end else begin
            dwell++;
         end
      end
   end

   task automatic push(input logic [3:0] st, input int en, input int li, input int dur);
      exp_t e;
      e.st  = st;
      e.en  = AW'(en);
      e.li  = AW'(li);
      e.dur = 8'(dur);
      q.push_back(e);
   endtask

   // Replay of items 0..lim before a response phase (nothing when replay is not built).
   task automatic push_show(input int lim);
`ifdef GENIUS_SHOW_SEQ_EN
      for (int i = 0; i <= lim; i++) begin
         push(MOSTRA, i, lim, 3);
         push(INTERVALO, i, lim, 2);
      end
      push(INICIO_RESP, 0, lim, 1);
`endif
      if (lim < 0) $display("bad lim");
   endtask

   function automatic int dly(input int k);
      return k % 3;
   endfunction

   // Expected trace of a full game started from PREPARA; play number err gets igual=0.
   task automatic push_game(input int last, input int err, output int nplays);
      int k;
      k = 0;
      push(PREPARA, 0, 0, 1);
      for (int lim = 0; lim <= last; lim++) begin
         if (lim > 0) push(PROX_RODADA, 0, lim, 1);
         push_show(lim);
         push(ESPERA, 0, lim, dly(k) + 1);
         for (int i = 0; i <= lim; i++) begin
            push(REGISTRA, i, lim, 1);
            push(COMPARA, i, lim, 1);
            if (k == err) begin
               push(FIM_ERRO, i, lim, 0);
               nplays = k + 1;
               return;
            end
            k++;
            if (i < lim) begin
               push(PROXIMO, i + 1, lim, 1);
               push(ESPERA, i + 1, lim, dly(k) + 1);
            end
         end
      end
      push(FIM_ACERTO, last, last, 0);
      nplays = k;
   endtask

   task automatic wait_state(input logic [3:0] st);
      int n;
      n = 0;
      while (bus.db_estado != st && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (bus.db_estado != st) begin
         checks++;
         errors++;
         $display("FAIL wait_st%0d: got state %0d, expected %0d within 300 cycles",
                  st, bus.db_estado, st);
      end
   endtask

   task automatic pulse_iniciar();
      @(negedge clock);
      bus.iniciar = 1'b1;
      @(negedge clock);
      bus.iniciar = 1'b0;
   endtask

   task automatic run_plays(input int n, input int err);
      for (int k = 0; k < n; k++) begin
         wait_state(ESPERA);
         repeat (dly(k)) @(negedge clock);
         bus.igual  = (k != err);
         bus.jogada = 1'b1;
         @(negedge clock);
         bus.jogada = 1'b0;
      end
   endtask

   initial begin
      int n;
      bus.iniciar = 1'b0;
      bus.modo    = 1'b0;
      bus.jogada  = 1'b0;
      bus.igual   = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_state", bus.db_estado, INICIAL);
      chk("reset_outputs", outs_dut(), outs_of(INICIAL));
      chk("reset_counters", {bus.endereco, bus.limite}, 0);
      reset   = 1'b1;
      cur_st  = INICIAL;
      cur_dur = 0;
      dwell   = 0;
      mon_en  = 1'b1;

      // Easy game, all correct: 2 rounds, 3 plays.
      push_game(1, -1, n);
      chk("easy_play_count", n, 3);
      pulse_iniciar();
      run_plays(n, -1);
      wait_state(FIM_ACERTO);

      // Full game with modo=1, modo dropped mid-game: 4 rounds, 10 plays.
      push_game(3, -1, n);
      chk("full_play_count", n, 10);
      bus.modo = 1'b1;
      pulse_iniciar();
      @(negedge clock);
      bus.modo = 1'b0;
      run_plays(n, -1);
      wait_state(FIM_ACERTO);

      // Wrong second play of round 1, then restart clears everything.
      push_game(1, 2, n);
      pulse_iniciar();
      run_plays(n, 2);
      wait_state(FIM_ERRO);

      // No play for 10 cycles -> timeout.
      push(PREPARA, 0, 0, 1);
      push_show(0);
      push(ESPERA, 0, 0, 10);
      push(FIM_TIMEOUT, 0, 0, 0);
      pulse_iniciar();
      wait_state(FIM_TIMEOUT);

      // Play on the 10th cycle wins over expiry; iniciar ignored in ESPERA; reset in COMPARA.
      push(PREPARA, 0, 0, 1);
      push_show(0);
      push(ESPERA, 0, 0, 10);
      push(REGISTRA, 0, 0, 1);
      push(COMPARA, 0, 0, 1);
      push(PROX_RODADA, 0, 1, 1);
      push_show(1);
      push(ESPERA, 0, 1, 2);
      push(REGISTRA, 0, 1, 1);
      push(COMPARA, 0, 1, 1);
      push(PROXIMO, 1, 1, 1);
      push(ESPERA, 1, 1, 1);
      push(REGISTRA, 1, 1, 1);
      push(COMPARA, 1, 1, 1);
      push(INICIAL, 0, 0, 0);
      pulse_iniciar();
      wait_state(ESPERA);
      repeat (9) @(negedge clock);
      bus.igual  = 1'b1;
      bus.jogada = 1'b1;
      @(negedge clock);
      bus.jogada = 1'b0;
      wait_state(ESPERA);
      bus.iniciar = 1'b1;
      @(negedge clock);
      bus.iniciar = 1'b0;
      bus.jogada  = 1'b1;
      @(negedge clock);
      bus.jogada = 1'b0;
      wait_state(ESPERA);
      bus.jogada = 1'b1;
      @(negedge clock);
      bus.jogada = 1'b0;
      wait_state(COMPARA);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("after_reset_state", bus.db_estado, INICIAL);

      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clock);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
